dc_pixel_assembler: RTL and testbench
=====================================

Name: dc_pixel_assembler

Overview:
- Front-end capture stage feeding the per-channel gamma LUTs.
- Takes the Dreamcast 12-bit half-pixel video bus plus syncs and pairs two consecutive halves into one RGB888 pixel.
- Produces aligned valid/sync/coordinate outputs.
- Latches the gamma selector at frame start, so gamma tables never change mid-frame.

Parameters:
- H_BITS, 11, width of the pixel-in-line counter.
- V_BITS, 10, width of the line-in-frame counter.

Ports:
- clock  in  1  pixel-bus clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_data  in  12  half-pixel data. Phase A = {R[7:0], G[7:4]}; phase B = {G[3:0], B[7:0]}.
- in_hsync  in  1  horizontal sync, active-high, already polarity-corrected.
- in_vsync  in  1  vertical sync, active-high.
- gamma_config_in  in  5  gamma selector from the control path, asynchronous to the frame.
- out_r, out_g, out_b  out  8 each  assembled pixel.
- out_valid  out  1  one-cycle strobe per assembled pixel.
- out_hsync, out_vsync  out  1 each  registered syncs, delay-matched to out_r/g/b.
- out_x  out  H_BITS  pixel index within the line; first pixel = 0.
- out_y  out  V_BITS  line index within the frame; first line after vsync = 0.
- gamma_config_out  out  5  frame-stable selector for the gamma stage.
- overflow  out  1  sticky; set when out_x saturates.

Behaviour:
- Reset (async, resetn low): all outputs 0, except gamma_config_out = GAMMA_BYPASS. State = WAIT_VSYNC, phase = 0, counters = 0, overflow = 0.
- Input stage: in_data, in_hsync and in_vsync are registered once (stage S0). Edges are detected between S0 and its previous value.
- State machine:
  - WAIT_VSYNC: on vsync rising edge → WAIT_HSYNC; out_y = 0.
  - WAIT_HSYNC: on hsync falling edge (end of sync) → ACTIVE; phase = 0; out_x = 0.
  - ACTIVE: phase toggles every cycle.
    - Phase A: hold the 12 bits.
    - Phase B: combine into RGB and assert out_valid the next cycle.
    - On hsync rising edge → WAIT_HSYNC. A held phase-A half is discarded; no out_valid is issued for it.
- Line counting: out_y increments on each hsync falling edge after the first in the frame, and saturates at all-ones.
- out_x: increments after each out_valid. If it would exceed all-ones, it holds at max, overflow sets, and state → WAIT_VSYNC.
- Vsync rising edge in any state: out_y = 0, gamma_config_out ← gamma_config_in, state → WAIT_HSYNC.
- Vsync rising and hsync falling in the same cycle: vsync is applied first, then the hsync → ACTIVE with out_y = 0.
- Latency: the phase-B sample on in_data appears on out_r/g/b with out_valid high exactly 3 clocks later (S0, assemble, output). out_hsync/out_vsync carry the same 3-clock delay.
- overflow clears only on reset.
- Reset mid-line: the output is abandoned immediately; nothing is emitted until the next vsync then hsync.

Optional Feature:
- DC_PIXEL_ASSEMBLER_STATS_EN defined:
  - Adds outputs stat_line_pixels[H_BITS] and stat_frame_lines[V_BITS].
  - stat_line_pixels latches the final out_x+1 at each hsync rising edge from ACTIVE.
  - stat_frame_lines latches out_y+1 at each vsync rising edge.
  - Both reset to 0.
- Undefined: both ports are still present and tied to 0; no counters are synthesised.

Decomposition:
- Shared package / include: state encoding (WAIT_VSYNC, WAIT_HSYNC, ACTIVE), GAMMA_BYPASS constant, and half-pixel bit-field positions.
- Sub-module: dc_sync_edge (register plus rise/fall pulse), instantiated for hsync and vsync.

Test Plan:
- Reset, then vsync pulse, hsync pulse, halves 0xAB1,0x2CD → out_r=0xAB, out_g=0x12, out_b=0xCD, out_valid 3 clocks after 0x2CD, out_x=0, out_y=0.
- 640 pixel pairs per line, 3 lines → out_x runs 0..639 each line; out_y = 0,1,2; exactly 1920 out_valid strobes.
- Odd half count (hsync rises after a phase-A half) → no extra out_valid; next line starts at phase A with out_x=0.
- gamma_config_in changes 0→5 mid-frame → gamma_config_out stays at its prior value, then becomes 5 on the cycle after the next vsync rising edge.
- Vsync rising and hsync falling in the same cycle → ACTIVE, out_y=0; first pixel has out_x=0.
- H_BITS=4 with a 20-pixel line → out_x holds at 15, overflow=1, no out_valid until the next vsync/hsync; assert resetn low mid-line → all outputs 0 asynchronously.

Source files
------------

// File: rtl/dc_pixel_assembler_pkg.sv
// -----------------------------------------------------------------------------
// dc_pixel_assembler_pkg
// Shared definitions for the Dreamcast half-pixel assembler:
//   - state_t       : capture state machine encoding
//   - GAMMA_BYPASS  : gamma selector value presented out of reset
//   - bit-field positions of the two 12-bit half-pixel phases
//       phase A = {R[7:0], G[7:4]}, phase B = {G[3:0], B[7:0]}
// -----------------------------------------------------------------------------
package dc_pixel_assembler_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        WAIT_HSYNC = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    localparam logic [4:0] GAMMA_BYPASS = 5'h1F;

    localparam int HALF_W  = 12;

    // Phase A fields
    localparam int A_R_MSB = 11;
    localparam int A_R_LSB = 4;
    localparam int A_G_MSB = 3;
    localparam int A_G_LSB = 0;

    // Phase B fields
    localparam int B_G_MSB = 11;
    localparam int B_G_LSB = 8;
    localparam int B_B_MSB = 7;
    localparam int B_B_LSB = 0;

endpackage

// File: rtl/dc_sync_edge.sv
// -----------------------------------------------------------------------------
// dc_sync_edge
// Registers one sync input and reports single-cycle rise/fall pulses derived
// from the registered value and its previous value.
// Ports:
//   clock  in   pixel-bus clock
//   resetn in   asynchronous active-low reset
//   raw    in   sync from the video bus
//   level  out  registered sync (input stage S0)
//   rise   out  S0 went 0 -> 1 this cycle
//   fall   out  S0 went 1 -> 0 this cycle
// -----------------------------------------------------------------------------
module dc_sync_edge
    import dc_pixel_assembler_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            level <= raw;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/dc_pixel_assembler.sv
// -----------------------------------------------------------------------------
// dc_pixel_assembler
// Pairs two consecutive 12-bit Dreamcast half-pixels into one RGB888 pixel and
// emits it with aligned valid, syncs and x/y coordinates. The gamma selector is
// captured on each vsync rising edge so downstream gamma tables stay fixed for
// a whole frame.
//
// Pipeline: S0 (input register) -> assemble -> output; a phase-B half appears
// on out_r/g/b with out_valid three clocks after it is driven on in_data.
//
// Ports:
//   clock, resetn            pixel clock, asynchronous active-low reset
//   in_data[11:0]            half-pixel bus (phase A then phase B)
//   in_hsync, in_vsync       active-high syncs
//   gamma_config_in[4:0]     gamma selector, asynchronous to the frame
//   out_r/out_g/out_b[7:0]   assembled pixel
//   out_valid                one-cycle strobe per pixel
//   out_hsync, out_vsync     syncs delayed to match the pixel
//   out_x[H_BITS-1:0]        pixel index within line
//   out_y[V_BITS-1:0]        line index within frame
//   gamma_config_out[4:0]    frame-stable gamma selector
//   overflow                 sticky, set when out_x saturates
//   stat_line_pixels         pixels in last completed line (stats build)
//   stat_frame_lines         lines in last completed frame (stats build)
//
// Build option: DC_PIXEL_ASSEMBLER_STATS_EN enables the line/frame statistics;
// without it both stat ports are tied to zero.
// -----------------------------------------------------------------------------
module dc_pixel_assembler
    import dc_pixel_assembler_pkg::*;
#(
    parameter int H_BITS = 11,
    parameter int V_BITS = 10
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [11:0]       in_data,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic [4:0]        gamma_config_in,
    output logic [7:0]        out_r,
    output logic [7:0]        out_g,
    output logic [7:0]        out_b,
    output logic              out_valid,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic [H_BITS-1:0] out_x,
    output logic [V_BITS-1:0] out_y,
    output logic [4:0]        gamma_config_out,
    output logic              overflow,
    output logic [H_BITS-1:0] stat_line_pixels,
    output logic [V_BITS-1:0] stat_frame_lines
);

    localparam logic [H_BITS-1:0] X_ONE = {{(H_BITS-1){1'b0}}, 1'b1};
    localparam logic [V_BITS-1:0] Y_ONE = {{(V_BITS-1){1'b0}}, 1'b1};

    state_t              state, state_nx;
    logic                phase;          // 0 = phase A, 1 = phase B
    logic [H_BITS-1:0]   x_cnt;          // pixels emitted on the current line
    logic [V_BITS-1:0]   y_cnt;
    logic                first_line;     // next hsync fall starts line 0
    logic                take_pix;
    logic                line_start;

    logic [HALF_W-1:0]   data_p0;
    logic [HALF_W-1:0]   hold_a;
    logic                hs_p0, hs_rise, hs_fall;
    logic                vs_p0, vs_rise, vs_fall_unused;

    logic [7:0]          r_p1, g_p1, b_p1;
    logic [H_BITS-1:0]   x_p1;
    logic [V_BITS-1:0]   y_p1;
    logic                vld_p1, hs_p1, vs_p1;

    // ---- Stage S0: input register and sync edge detection ----
    dc_sync_edge u_hsync_edge (
        .clock  (clock),
        .resetn (resetn),
        .raw    (in_hsync),
        .level  (hs_p0),
        .rise   (hs_rise),
        .fall   (hs_fall)
    );

    dc_sync_edge u_vsync_edge (
        .clock  (clock),
        .resetn (resetn),
        .raw    (in_vsync),
        .level  (vs_p0),
        .rise   (vs_rise),
        .fall   (vs_fall_unused)
    );

    always_ff @(posedge clock) begin
        data_p0 <= in_data;
    end

    // Vsync is resolved first so a simultaneous hsync fall starts line 0.
    always_comb begin
        state_nx   = state;
        take_pix   = 1'b0;
        line_start = 1'b0;
        if (vs_rise) begin
            if (hs_fall) begin
                state_nx   = ACTIVE;
                line_start = 1'b1;
            end else begin
                state_nx   = WAIT_HSYNC;
            end
        end else begin
            case (state)
                WAIT_VSYNC: state_nx = WAIT_VSYNC;
                WAIT_HSYNC: begin
                    if (hs_fall) begin
                        state_nx   = ACTIVE;
                        line_start = 1'b1;
                    end
                end
                ACTIVE: begin
                    // hsync rising wins over a coincident phase-B half, so a
                    // dangling phase-A half is dropped.
                    if (hs_rise) begin
                        state_nx = WAIT_HSYNC;
                    end else if (phase) begin
                        take_pix = 1'b1;
                        if (x_cnt == '1) state_nx = WAIT_VSYNC;
                    end
                end
                default: state_nx = WAIT_VSYNC;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= WAIT_VSYNC;
            phase            <= 1'b0;
            x_cnt            <= '0;
            y_cnt            <= '0;
            first_line       <= 1'b0;
            overflow         <= 1'b0;
            gamma_config_out <= GAMMA_BYPASS;
        end else begin
            state <= state_nx;

            if (line_start) begin
                phase <= 1'b0;
                x_cnt <= '0;
            end else if (state == ACTIVE) begin
                phase <= ~phase;
            end

            if (take_pix) begin
                if (x_cnt == '1) overflow <= 1'b1;
                else             x_cnt    <= x_cnt + X_ONE;
            end

            if (vs_rise) begin
                y_cnt            <= '0;
                first_line       <= 1'b1;
                gamma_config_out <= gamma_config_in;
            end

            if (line_start) begin
                if (vs_rise || first_line) first_line <= 1'b0;
                else if (y_cnt != '1)      y_cnt      <= y_cnt + Y_ONE;
            end
        end
    end

    // ---- Stage p1: assemble ----
    always_ff @(posedge clock) begin
        if (state == ACTIVE && !phase) begin
            hold_a <= data_p0;
        end
        if (take_pix) begin
            r_p1 <= hold_a[A_R_MSB:A_R_LSB];
            g_p1 <= {hold_a[A_G_MSB:A_G_LSB], data_p0[B_G_MSB:B_G_LSB]};
            b_p1 <= data_p0[B_B_MSB:B_B_LSB];
            x_p1 <= x_cnt;
            y_p1 <= y_cnt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            vld_p1 <= take_pix;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
        end
    end

    // ---- Stage p2: output ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= vld_p1;
            out_hsync <= hs_p1;
            out_vsync <= vs_p1;
            if (vld_p1) begin
                out_r <= r_p1;
                out_g <= g_p1;
                out_b <= b_p1;
                out_x <= x_p1;
                out_y <= y_p1;
            end
        end
    end

`ifdef DC_PIXEL_ASSEMBLER_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stat_line_pixels <= '0;
            stat_frame_lines <= '0;
        end else begin
            // x_cnt already equals the final out_x + 1 when the line closes.
            if (hs_rise && !vs_rise && state == ACTIVE) stat_line_pixels <= x_cnt;
            if (vs_rise) stat_frame_lines <= y_cnt + Y_ONE;
        end
    end
`else
    assign stat_line_pixels = '0;
    assign stat_frame_lines = '0;
`endif

endmodule

// File: tb/tb_dc_pixel_assembler.sv
// -----------------------------------------------------------------------------
// tb_dc_pixel_assembler
// Scoreboard bench: stimulus tasks push expected pixels (including the cycle
// they must appear on) into queues; negedge monitors pop and compare whenever
// a DUT asserts out_valid. A second instance with H_BITS=4 covers saturation.
// -----------------------------------------------------------------------------
module tb_dc_pixel_assembler;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         x;
        int         y;
        int         ecyc;
    } exp_t;

    logic        clock;
    logic        resetn;
    logic [11:0] in_data;
    logic        in_hsync;
    logic        in_vsync;
    logic [4:0]  gamma_config_in;

    logic [7:0]  out_r, out_g, out_b;
    logic        out_valid, out_hsync, out_vsync;
    logic [10:0] out_x;
    logic [9:0]  out_y;
    logic [4:0]  gamma_config_out;
    logic        overflow;
    logic [10:0] stat_line_pixels;
    logic [9:0]  stat_frame_lines;

    logic [7:0]  o4_r, o4_g, o4_b;
    logic        o4_valid, o4_hsync, o4_vsync;
    logic [3:0]  o4_x;
    logic [9:0]  o4_y;
    logic [4:0]  o4_gamma;
    logic        o4_overflow;
    logic [3:0]  o4_stat_lp;
    logic [9:0]  o4_stat_fl;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   vcount = 0;
    bit   chk4   = 0;
    exp_t exp_q[$];
    exp_t exp4_q[$];
    exp_t me, me4;

    dc_pixel_assembler dut (
        .clock            (clock),
        .resetn           (resetn),
        .in_data          (in_data),
        .in_hsync         (in_hsync),
        .in_vsync         (in_vsync),
        .gamma_config_in  (gamma_config_in),
        .out_r            (out_r),
        .out_g            (out_g),
        .out_b            (out_b),
        .out_valid        (out_valid),
        .out_hsync        (out_hsync),
        .out_vsync        (out_vsync),
        .out_x            (out_x),
        .out_y            (out_y),
        .gamma_config_out (gamma_config_out),
        .overflow         (overflow),
        .stat_line_pixels (stat_line_pixels),
        .stat_frame_lines (stat_frame_lines)
    );

    dc_pixel_assembler #(.H_BITS(4), .V_BITS(10)) dut4 (
        .clock            (clock),
        .resetn           (resetn),
        .in_data          (in_data),
        .in_hsync         (in_hsync),
        .in_vsync         (in_vsync),
        .gamma_config_in  (gamma_config_in),
        .out_r            (o4_r),
        .out_g            (o4_g),
        .out_b            (o4_b),
        .out_valid        (o4_valid),
        .out_hsync        (o4_hsync),
        .out_vsync        (o4_vsync),
        .out_x            (o4_x),
        .out_y            (o4_y),
        .gamma_config_out (o4_gamma),
        .overflow         (o4_overflow),
        .stat_line_pixels (o4_stat_lp),
        .stat_frame_lines (o4_stat_fl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitors
    always @(negedge clock) begin
        if (out_valid) begin
            vcount++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got valid x=%0d y=%0d at cycle %0d, required no valid", out_x, out_y, cyc);
            end else begin
                me = exp_q.pop_front();
                if (out_r !== me.r || out_g !== me.g || out_b !== me.b ||
                    int'(out_x) != me.x || int'(out_y) != me.y || cyc != me.ecyc) begin
                    errors++;
                    $display("FAIL pixel: got rgb=%h_%h_%h x=%0d y=%0d cyc=%0d, required rgb=%h_%h_%h x=%0d y=%0d cyc=%0d",
                             out_r, out_g, out_b, out_x, out_y, cyc, me.r, me.g, me.b, me.x, me.y, me.ecyc);
                end
            end
        end
        if (chk4 && o4_valid) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid_h4: got valid x=%0d at cycle %0d, required no valid", o4_x, cyc);
            end else begin
                me4 = exp4_q.pop_front();
                if (o4_r !== me4.r || o4_g !== me4.g || o4_b !== me4.b ||
                    int'(o4_x) != me4.x || int'(o4_y) != me4.y || cyc != me4.ecyc) begin
                    errors++;
                    $display("FAIL pixel_h4: got rgb=%h_%h_%h x=%0d y=%0d cyc=%0d, required rgb=%h_%h_%h x=%0d y=%0d cyc=%0d",
                             o4_r, o4_g, o4_b, o4_x, o4_y, cyc, me4.r, me4.g, me4.b, me4.x, me4.y, me4.ecyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] a, input logic [11:0] b,
                                input int x, input int y, input int c);
        exp_t e;
        e.r    = a[11:4];
        e.g    = {a[3:0], b[11:8]};
        e.b    = b[7:0];
        e.x    = x;
        e.y    = y;
        e.ecyc = c;
        return e;
    endfunction

    // Drive one bus cycle; values are sampled at the next rising edge.
    task automatic drv(input logic [11:0] d, input logic hs, input logic vs);
        in_data  = d;
        in_hsync = hs;
        in_vsync = vs;
        @(posedge clock);
        #1;
    endtask

    task automatic vpulse();
        drv(12'h000, 1'b1, 1'b1);
        drv(12'h000, 1'b1, 1'b1);
        drv(12'h000, 1'b1, 1'b0);
    endtask

    task automatic hstart();
        drv(12'h000, 1'b1, 1'b0);
        drv(12'h000, 1'b0, 1'b0);
    endtask

    task automatic hend();
        drv(12'h000, 1'b1, 1'b0);
    endtask

    task automatic send_line(input int n, input int y, input int seed,
                             input bit pm, input int lim4);
        logic [11:0] a, b;
        int cb;
        for (int i = 0; i < n; i++) begin
            a = 12'(seed + i * 37);
            b = 12'(seed * 3 + i * 91 + 1);
            drv(a, 1'b0, 1'b0);
            cb = cyc;
            drv(b, 1'b0, 1'b0);
            if (pm)       exp_q.push_back(mk(a, b, i, y, cb + 3));
            if (i < lim4) exp4_q.push_back(mk(a, b, i, y, cb + 3));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) begin
            @(posedge clock);
            #1;
        end
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("queue4_drained", 32'(exp4_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e1;
        int   cb, vbase;

        resetn          = 1'b1;
        in_data         = '0;
        in_hsync        = 1'b0;
        in_vsync        = 1'b0;
        gamma_config_in = 5'd0;
        #3 resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", {8'h0, out_r, out_g, out_b}, 32'd0);
        chk("rst_xy", {11'h0, out_x, out_y}, 32'd0);
        chk("rst_syncs", {30'h0, out_hsync, out_vsync}, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_gamma", 32'(gamma_config_out), 32'h1F);
        chk("rst_stats", {11'h0, stat_line_pixels, stat_frame_lines}, 32'd0);
        resetn = 1'b1;
        drv(12'h000, 1'b0, 1'b0);

        // First pixel, latency 3 from phase-B drive
        vpulse();
        chk("gamma_first_frame", 32'(gamma_config_out), 32'd0);
        hstart();
        drv(12'hAB1, 1'b0, 1'b0);
        cb = cyc;
        drv(12'h2CD, 1'b0, 1'b0);
        e1.r = 8'hAB; e1.g = 8'h12; e1.b = 8'hCD; e1.x = 0; e1.y = 0; e1.ecyc = cb + 3;
        exp_q.push_back(e1);
        hend();
        drain();

        // Three 640-pixel lines; gamma input changes mid-frame
        vpulse();
        vbase = vcount;
        for (int y = 0; y < 3; y++) begin
            hstart();
            if (y == 1) gamma_config_in = 5'd5;
            send_line(640, y, 100 + y * 11, 1'b1, 0);
            hend();
        end
        drain();
        chk("valid_count_1920", 32'(vcount - vbase), 32'd1920);
        chk("gamma_held_midframe", 32'(gamma_config_out), 32'd0);
        chk("no_overflow_640", 32'(overflow), 32'd0);

        // Gamma latched only by the next vsync; out_vsync delay
        drv(12'h000, 1'b1, 1'b1);
        chk("gamma_before_latch", 32'(gamma_config_out), 32'd0);
        drv(12'h000, 1'b1, 1'b1);
        chk("gamma_after_vsync", 32'(gamma_config_out), 32'd5);
        chk("out_vsync_early", 32'(out_vsync), 32'd0);
        drv(12'h000, 1'b1, 1'b0);
        chk("out_vsync_delay3", 32'(out_vsync), 32'd1);

        // Odd half count: dangling phase-A half is dropped
        hstart();
        send_line(3, 0, 7, 1'b1, 0);
        drv(12'hFFF, 1'b0, 1'b0);
        hend();
        drv(12'h000, 1'b1, 1'b0);
        chk("out_hsync_early", 32'(out_hsync), 32'd0);
        drv(12'h000, 1'b1, 1'b0);
        chk("out_hsync_delay3", 32'(out_hsync), 32'd1);
        hstart();
        send_line(2, 1, 300, 1'b1, 0);
        hend();
        drain();

        // Vsync rise and hsync fall in the same cycle
        drv(12'h000, 1'b1, 1'b0);
        drv(12'h000, 1'b0, 1'b1);
        send_line(2, 0, 555, 1'b1, 0);
        hend();
        drain();

        // H_BITS=4 saturation
        resetn = 1'b0;
        drv(12'h000, 1'b1, 1'b0);
        drv(12'h000, 1'b1, 1'b0);
        chk("h4_overflow_reset", 32'(o4_overflow), 32'd0);
        resetn = 1'b1;
        chk4 = 1'b1;
        vpulse();
        hstart();
        send_line(20, 0, 900, 1'b1, 16);
        hend();
        drain();
        chk("h4_overflow_set", 32'(o4_overflow), 32'd1);
        chk("h4_x_held", 32'(o4_x), 32'd15);
        chk("main_no_overflow_20", 32'(overflow), 32'd0);
        hstart();
        send_line(4, 1, 40, 1'b1, 0);
        hend();
        drain();
        vpulse();
        hstart();
        send_line(2, 0, 70, 1'b1, 16);
        hend();
        drain();
        chk("h4_overflow_sticky", 32'(o4_overflow), 32'd1);
        chk4 = 1'b0;

        // Reset mid-line
        vpulse();
        hstart();
        send_line(2, 0, 1234, 1'b1, 0);
        send_line(2, 0, 4321, 1'b0, 0);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_rgb", {8'h0, out_r, out_g, out_b}, 32'd0);
        chk("midrst_x", 32'(out_x), 32'd0);
        chk("midrst_gamma", 32'(gamma_config_out), 32'h1F);
        chk("midrst_h4_overflow", 32'(o4_overflow), 32'd0);
        drv(12'h000, 1'b0, 1'b0);
        drv(12'h000, 1'b0, 1'b0);
        resetn = 1'b1;
        send_line(6, 0, 10, 1'b0, 0);
        hend();
        hstart();
        send_line(2, 0, 20, 1'b0, 0);
        hend();
        drain();
        vpulse();
        chk("gamma_after_reset_frame", 32'(gamma_config_out), 32'd5);
        hstart();
        send_line(1, 0, 2000, 1'b1, 0);
        hend();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
